// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for the PLL config register controller
package spi_reg_pkg;

  localparam int REG_W    = 8;
  localparam int NUM_REGS = 16;

  localparam logic [3:0] ADDR_ID     = 4'd0;
  localparam logic [3:0] ADDR_COMMIT = 4'd14;
  localparam logic [3:0] ADDR_STAT   = 4'd15;

  // Requester slots on the arbiter
  localparam int GNT_SPI = 0;
  localparam int GNT_LOC = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/spi_reg_arb.sv
// rtl/spi_reg_arb.sv - 2-way round-robin arbiter holding the last-granted pointer
module spi_reg_arb
  import spi_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_loc;

  // On a tie the requester that was not granted last wins
  always_comb begin
    gnt = 2'b00;
    if (req[GNT_LOC] && (!req[GNT_SPI] || !last_loc)) begin
      gnt[GNT_LOC] = 1'b1;
    end else if (req[GNT_SPI]) begin
      gnt[GNT_SPI] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_loc <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      last_loc <= gnt[GNT_LOC];
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI/local register bank controller for PLL config; SPI_REG_SHADOW_EN adds a shadow bank
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter logic [REG_W-1:0]          DEV_ID  = 8'hA5,
  parameter logic [REG_W*NUM_REGS-1:0] CFG_RST = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_valid,
  input  logic                      spi_rw,
  input  logic [3:0]                spi_addr,
  input  logic [REG_W-1:0]          spi_wdata,
  output logic [REG_W-1:0]          spi_rdata,
  input  logic                      loc_req,
  input  logic                      loc_we,
  input  logic [3:0]                loc_addr,
  input  logic [REG_W-1:0]          loc_wdata,
  output logic                      loc_ack,
  output logic [REG_W-1:0]          loc_rdata,
  input  logic [6:0]                stat_in,
  output logic [REG_W*NUM_REGS-1:0] cfg_out,
  output logic                      cfg_upd,
  output logic                      spi_ovf
);

  state_t state, state_nxt;
  logic [1:0] gnt_q, gnt_nxt;
  logic [1:0] arb_req, arb_gnt;
  logic       advance;

  logic             spi_pend;
  logic             pend_rw;
  logic [3:0]       pend_addr;
  logic [REG_W-1:0] pend_wdata;

  logic             is_spi, is_loc;
  logic             acc_we, wr_en;
  logic [3:0]       acc_addr;
  logic [REG_W-1:0] acc_wdata, rd_val;
  logic             spi_drop;

  logic [REG_W-1:0] live_q [1:NUM_REGS-2];
`ifdef SPI_REG_SHADOW_EN
  logic [REG_W-1:0] shadow_q [1:NUM_REGS-3];
  logic             commit;
`endif

  // While an access is in flight the arbiter only sees the granted requester,
  // so advance records the grant actually served.
  assign arb_req = (state == ACCESS) ? gnt_q : {loc_req, spi_pend};
  assign advance = (state == ACCESS);

  spi_reg_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (advance),
    .gnt     (arb_gnt)
  );

  assign is_spi    = (state == ACCESS) && gnt_q[GNT_SPI];
  assign is_loc    = (state == ACCESS) && gnt_q[GNT_LOC];
  assign acc_we    = is_spi ? pend_rw    : loc_we;
  assign acc_addr  = is_spi ? pend_addr  : loc_addr;
  assign acc_wdata = is_spi ? pend_wdata : loc_wdata;
  assign wr_en     = (is_spi || is_loc) && acc_we;
  assign spi_drop  = spi_valid && spi_pend && !is_spi;

  // Read view: shadow contents for 1..13 when the shadow bank exists
  always_comb begin
    rd_val = '0;
`ifdef SPI_REG_SHADOW_EN
    for (int i = 1; i <= NUM_REGS - 3; i++) begin
      if (acc_addr == 4'(i)) rd_val = shadow_q[i];
    end
    if (acc_addr == ADDR_COMMIT) rd_val = live_q[ADDR_COMMIT];
`else
    for (int i = 1; i <= NUM_REGS - 2; i++) begin
      if (acc_addr == 4'(i)) rd_val = live_q[i];
    end
`endif
    if (acc_addr == ADDR_ID)   rd_val = DEV_ID;
    if (acc_addr == ADDR_STAT) rd_val = {spi_ovf, stat_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= 2'b00;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    loc_ack   = 1'b0;
    loc_rdata = '0;
    case (state)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          gnt_nxt   = arb_gnt;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
        if (gnt_q[GNT_LOC]) begin
          loc_ack   = 1'b1;
          loc_rdata = loc_we ? '0 : rd_val;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A frame arriving while one is still waiting (and not being served) is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_pend   <= 1'b0;
      pend_rw    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
    end else if (spi_valid && !spi_drop) begin
      spi_pend   <= 1'b1;
      pend_rw    <= spi_rw;
      pend_addr  <= spi_addr;
      pend_wdata <= spi_wdata;
    end else if (is_spi) begin
      spi_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_ovf <= 1'b0;
    end else if (spi_drop) begin
      spi_ovf <= 1'b1;
    end else if (wr_en && (acc_addr == ADDR_STAT) && acc_wdata[7]) begin
      spi_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_rdata <= '0;
    end else if (is_spi && !pend_rw) begin
      spi_rdata <= rd_val;
    end
  end

`ifdef SPI_REG_SHADOW_EN
  assign commit = wr_en && (acc_addr == ADDR_COMMIT) && acc_wdata[0];

  // Reg 14 bit0 is a commit strobe and never stays set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= NUM_REGS - 3; i++) begin
        shadow_q[i] <= CFG_RST[REG_W*i +: REG_W];
        live_q[i]   <= CFG_RST[REG_W*i +: REG_W];
      end
      live_q[ADDR_COMMIT] <= CFG_RST[REG_W*ADDR_COMMIT +: REG_W];
      cfg_upd             <= 1'b0;
    end else begin
      cfg_upd <= wr_en && (acc_addr == ADDR_COMMIT);
      for (int i = 1; i <= NUM_REGS - 3; i++) begin
        if (wr_en && (acc_addr == 4'(i))) shadow_q[i] <= acc_wdata;
        if (commit)                       live_q[i]   <= shadow_q[i];
      end
      if (wr_en && (acc_addr == ADDR_COMMIT)) begin
        live_q[ADDR_COMMIT] <= {acc_wdata[REG_W-1:1], 1'b0};
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= NUM_REGS - 2; i++) begin
        live_q[i] <= CFG_RST[REG_W*i +: REG_W];
      end
      cfg_upd <= 1'b0;
    end else begin
      cfg_upd <= wr_en && (acc_addr != ADDR_ID) && (acc_addr != ADDR_STAT);
      for (int i = 1; i <= NUM_REGS - 2; i++) begin
        if (wr_en && (acc_addr == 4'(i))) live_q[i] <= acc_wdata;
      end
    end
  end
`endif

  always_comb begin
    cfg_out = '0;
    cfg_out[REG_W-1:0] = DEV_ID;
    for (int i = 1; i <= NUM_REGS - 2; i++) begin
      cfg_out[REG_W*i +: REG_W] = live_q[i];
    end
    cfg_out[REG_W*NUM_REGS-1 -: REG_W] = {spi_ovf, stat_in};
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard bench for spi_reg_ctrl (default and SPI_REG_SHADOW_EN builds)
module tb_spi_reg_ctrl;

  localparam logic [127:0] CFG_RST_TB = 128'h5A << 40;
`ifdef SPI_REG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         spi_valid = 1'b0, spi_rw = 1'b0;
  logic [3:0]   spi_addr = '0;
  logic [7:0]   spi_wdata = '0;
  logic [7:0]   spi_rdata;
  logic         loc_req = 1'b0, loc_we = 1'b0;
  logic [3:0]   loc_addr = '0;
  logic [7:0]   loc_wdata = '0;
  logic         loc_ack;
  logic [7:0]   loc_rdata;
  logic [6:0]   stat_in = 7'h12;
  logic [127:0] cfg_out;
  logic         cfg_upd;
  logic         spi_ovf;

  spi_reg_ctrl #(.DEV_ID(8'hA5), .CFG_RST(CFG_RST_TB)) dut (
    .clk(clk), .rst(rst),
    .spi_valid(spi_valid), .spi_rw(spi_rw), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_ack(loc_ack), .loc_rdata(loc_rdata),
    .stat_in(stat_in), .cfg_out(cfg_out), .cfg_upd(cfg_upd), .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0]  spi_q [$];
  logic [7:0]  loc_q [$];
  logic [11:0] upd_q [$];
  logic [7:0]  spi_exp = 8'h00;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit lands_live(input logic [3:0] a);
    return (a != 4'd0) && (a != 4'd15) && (!SHADOW || a == 4'd14);
  endfunction

  task automatic push_upd(input logic [3:0] a, input logic [7:0] d);
    if (lands_live(a)) upd_q.push_back({a, d});
  endtask

  // Slave shifts spi_rdata out during the next frame, so it is checked on each spi_valid
  always @(negedge clk) begin
    if (!rst) begin
      if (spi_valid) begin
        if (spi_q.size() == 0) chk("spi_rdata_unexpected_frame", 1, 0);
        else chk("spi_rdata", spi_rdata, spi_q.pop_front());
      end
      if (loc_ack) begin
        if (loc_q.size() == 0) chk("loc_ack_unexpected", 1, 0);
        else chk("loc_rdata", loc_rdata, loc_q.pop_front());
      end
      if (cfg_upd) begin
        if (upd_q.size() == 0) chk("cfg_upd_unexpected", 1, 0);
        else begin
          logic [11:0] e;
          int a;
          e = upd_q.pop_front();
          a = int'(e[11:8]);
          chk("cfg_out_on_upd", cfg_out[8*a +: 8], e[7:0]);
        end
      end
    end
  end

  task automatic spi_frame(input logic rw, input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    spi_valid = 1'b1; spi_rw = rw; spi_addr = a; spi_wdata = d;
    spi_q.push_back(spi_exp);
    @(posedge clk); #1;
    spi_valid = 1'b0;
  endtask

  task automatic spi_op(input logic rw, input logic [3:0] a, input logic [7:0] d);
    if (rw) push_upd(a, d);
    spi_frame(rw, a, d);
    if (!rw) spi_exp = d;
    repeat (4) @(posedge clk);
  endtask

  task automatic loc_op(input logic we, input logic [3:0] a, input logic [7:0] d);
    int n;
    @(posedge clk); #1;
    loc_req = 1'b1; loc_we = we; loc_addr = a; loc_wdata = d;
    loc_q.push_back(we ? 8'h00 : d);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (loc_ack) break;
    end
    if (n == 20) chk("loc_ack_timeout", 0, 1);
    @(posedge clk); #1;
    loc_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    spi_exp = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_spi_rdata", spi_rdata, 8'h00);
    chk("rst_loc_ack", loc_ack, 1'b0);
    chk("rst_cfg_upd", cfg_upd, 1'b0);
    chk("rst_spi_ovf", spi_ovf, 1'b0);
    chk("rst_cfg_out", cfg_out, CFG_RST_TB | 128'hA5 | (128'h12 << 120));

    // Reads of ID and status registers
    spi_op(1'b0, 4'd0, 8'hA5);
    spi_op(1'b0, 4'd15, 8'h12);

    // Write latency and read-only write
    push_upd(4'd3, 8'h5C);
    spi_frame(1'b1, 4'd3, 8'h5C);
    @(posedge clk); #1;
    chk("wr3_before_3clk", cfg_out[31:24], 8'h00);
    @(posedge clk); #1;
    chk("wr3_at_3clk", cfg_out[31:24], SHADOW ? 8'h00 : 8'h5C);
    repeat (3) @(posedge clk);
    spi_op(1'b1, 4'd0, 8'hFF);
    spi_op(1'b0, 4'd0, 8'hA5);
    chk("reg0_cfg_out", cfg_out[7:0], 8'hA5);

    // Simultaneous SPI and local after reset: local first
    do_reset();
    push_upd(4'd2, 8'h11);
    push_upd(4'd6, 8'h66);
    fork
      loc_op(1'b1, 4'd2, 8'h11);
      spi_frame(1'b1, 4'd6, 8'h66);
    join
    repeat (4) @(posedge clk);
    // True tie after an SPI grant goes to local; the consume+new frame edge must not overflow
    push_upd(4'd7, 8'h77);
    push_upd(4'd8, 8'h88);
    push_upd(4'd9, 8'h99);
    spi_frame(1'b1, 4'd7, 8'h77);
    fork
      spi_frame(1'b1, 4'd9, 8'h99);
      loc_op(1'b1, 4'd8, 8'h88);
    join
    repeat (5) @(posedge clk);
    chk("no_ovf_on_consume", spi_ovf, 1'b0);

    // Overflow: second frame arrives while the first still waits behind local
    fork
      loc_op(1'b0, 4'd2, 8'h11);
      begin
        spi_frame(1'b0, 4'd6, 8'h66);
        spi_frame(1'b1, 4'd3, 8'hEE);
        spi_exp = 8'h66;
      end
    join
    repeat (4) @(posedge clk);
    chk("ovf_set", spi_ovf, 1'b1);
    spi_op(1'b0, 4'd15, 8'h92);
    spi_op(1'b1, 4'd15, 8'h80);
    chk("ovf_cleared", spi_ovf, 1'b0);
    spi_op(1'b0, 4'd3, 8'h00);
    spi_op(1'b0, 4'd15, 8'h12);

    // Reset in the middle of a local write access
    @(posedge clk); #1;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 4'd5; loc_wdata = 8'hC3;
    @(posedge clk); #1;
    chk("ack_in_access", loc_ack, 1'b1);
    rst = 1'b1;
    #1;
    chk("ack_aborted", loc_ack, 1'b0);
    loc_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    spi_exp = 8'h00;
    chk("reg5_after_abort", cfg_out[47:40], 8'h5A);
    spi_op(1'b0, 4'd5, 8'h5A);

`ifdef SPI_REG_SHADOW_EN
    spi_op(1'b1, 4'd4, 8'h33);
    chk("shadow_live_held", cfg_out[39:32], 8'h00);
    spi_op(1'b0, 4'd4, 8'h33);
    upd_q.push_back({4'd4, 8'h33});
    spi_frame(1'b1, 4'd14, 8'h01);
    repeat (4) @(posedge clk);
    chk("commit_reg14_live", cfg_out[119:112], 8'h00);
    spi_op(1'b0, 4'd14, 8'h00);
`else
    spi_op(1'b1, 4'd14, 8'h01);
    spi_op(1'b0, 4'd14, 8'h01);
    chk("reg14_plain", cfg_out[119:112], 8'h01);
`endif

    // Final frame shifts out the last read result
    spi_op(1'b0, 4'd0, 8'hA5);
    repeat (2) @(posedge clk);
    chk("spi_q_drained", spi_q.size(), 0);
    chk("loc_q_drained", loc_q.size(), 0);
    chk("upd_q_drained", upd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
